// File: rtl/freq_gate_ctrl.sv
// Measurement sequencer for the 6-digit BCD frequency counter chain:
// clear -> gate -> latch -> hold, with long/short gate auto-ranging on overflow.
module freq_gate_ctrl #(
  parameter int GATE_LONG  = 4,
  parameter int GATE_SHORT = 1,
  parameter int HOLD_CYC   = 2
) (
  input  logic        clk_05,
  input  logic        Rst_n,
  input  logic        start,
  input  logic        cont_mode,
  input  logic        hold,
  input  logic [23:0] bcd_in,
  input  logic        ovf_in,
  output logic        cnt_clr,
  output logic        gate_en,
  output logic [23:0] data_out,
  output logic        range,
  output logic        ovf_flag,
  output logic        meas_valid
);

  localparam int CNT_MAX = (GATE_LONG > HOLD_CYC) ? GATE_LONG : HOLD_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // One-hot encoding lets cnt_clr and gate_en come straight from state flops.
  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_CLR   = 5'b00010,
    S_GATE  = 5'b00100,
    S_LATCH = 5'b01000,
    S_HOLD  = 5'b10000
  } state_t;

  localparam int CLR_BIT  = 1;
  localparam int GATE_BIT = 2;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               ovf_seen_q;
  logic [23:0]        data_q;
  logic               range_q;
  logic               ovf_flag_q;
  logic               valid_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_05 or negedge Rst_n) begin
    if (!Rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: state_d gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start || cont_mode) state_d = S_CLR;
      S_CLR:   state_d = S_GATE;
      S_GATE:  if (cnt_q == '0) state_d = S_LATCH;
      S_LATCH: state_d = (ovf_seen_q && !range_q) ? S_CLR : S_HOLD;
      S_HOLD:  if (cnt_q == '0 && !hold) state_d = cont_mode ? S_CLR : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_clr    = state_q[CLR_BIT];
    gate_en    = state_q[GATE_BIT];
    data_out   = data_q;
    range      = range_q;
    ovf_flag   = ovf_flag_q;
    meas_valid = valid_q;
  end

  // NOTE: every datapath register is reset so an aborted measurement publishes nothing.
  always_ff @(posedge clk_05 or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_q      <= '0;
      ovf_seen_q <= 1'b0;
      data_q     <= '0;
      range_q    <= 1'b0;
      ovf_flag_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_CLR: begin
          cnt_q      <= range_q ? CNT_W'(GATE_SHORT - 1) : CNT_W'(GATE_LONG - 1);
          ovf_seen_q <= 1'b0;
        end
        S_GATE: begin
          ovf_seen_q <= ovf_seen_q | ovf_in;
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        end
        S_LATCH: begin
          cnt_q <= CNT_W'(HOLD_CYC - 1);
          if (ovf_seen_q) begin
            if (!range_q) begin
              range_q <= 1'b1;
            end else begin
              ovf_flag_q <= 1'b1;
              valid_q    <= 1'b1;
            end
          end else begin
            data_q     <= bcd_in;
            ovf_flag_q <= 1'b0;
            valid_q    <= 1'b1;
            // Short gate with empty top two digits: go back to the long gate.
            if (range_q && bcd_in[23:16] == 8'h00) range_q <= 1'b0;
          end
        end
        S_HOLD: if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

endmodule
